// File: rtl/reg_read_bypass_stage_pkg.sv
// Shared types and defaults for the register-read / bypass stage.
package reg_read_bypass_stage_pkg;

  localparam int unsigned DefNumBypass = 4;
  localparam int unsigned DefPregIdxW  = 6;

  typedef enum logic [1:0] {
    REG_FILE = 2'd0,
    BYPASS   = 2'd1,
    ZERO     = 2'd2
  } bypass_sel_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/operand_bypass_sel.sv
// Resolves one source operand: x0 forces zero, else lowest-index matching bypass, else regfile.
module operand_bypass_sel
  import reg_read_bypass_stage_pkg::*;
#(
  parameter int unsigned NUM_BYPASS = DefNumBypass,
  parameter int unsigned PREG_IDX_W = DefPregIdxW,
  parameter int unsigned XLEN       = 32
) (
  input  logic [PREG_IDX_W-1:0]            idx,
  input  logic [NUM_BYPASS-1:0]            byp_valid,
  input  logic [NUM_BYPASS*PREG_IDX_W-1:0] byp_dst,
  input  logic [NUM_BYPASS*XLEN-1:0]       byp_value,
  input  logic [XLEN-1:0]                  rf_data,
  output logic [XLEN-1:0]                  value,
  output bypass_sel_e                      sel
);

  logic found;

  always_comb begin
    value = rf_data;
    sel   = REG_FILE;
    found = 1'b0;
    for (int b = 0; b < NUM_BYPASS; b++) begin
      if (!found && byp_valid[b] && (byp_dst[b*PREG_IDX_W +: PREG_IDX_W] == idx)) begin
        found = 1'b1;
        value = byp_value[b*XLEN +: XLEN];
        sel   = BYPASS;
      end
    end
    if (idx == '0) begin
      value = '0;
      sel   = ZERO;
    end
  end

endmodule

// File: rtl/reg_read_bypass_stage.sv
// Register-read stage: resolves operands per lane and registers them toward execute.
// Optional RR_BYPASS_STATS_EN adds saturating bypass-hit / regfile-read counters.
module reg_read_bypass_stage
  import reg_read_bypass_stage_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned NUM_BYPASS = DefNumBypass,
  parameter int unsigned PREG_IDX_W = DefPregIdxW,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PAYLOAD_W  = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_PORTS-1:0]              in_valid,
  output logic                              in_ready,
  input  logic [NUM_PORTS*PREG_IDX_W-1:0]   in_src1_idx,
  input  logic [NUM_PORTS*PREG_IDX_W-1:0]   in_src2_idx,
  input  logic [NUM_PORTS*PAYLOAD_W-1:0]    in_payload,
  output logic [2*NUM_PORTS*PREG_IDX_W-1:0] rf_rd_idx,
  input  logic [2*NUM_PORTS*XLEN-1:0]       rf_rd_data,
  input  logic [NUM_BYPASS-1:0]             byp_valid,
  input  logic [NUM_BYPASS*PREG_IDX_W-1:0]  byp_dst,
  input  logic [NUM_BYPASS*XLEN-1:0]        byp_value,
  output logic [NUM_PORTS-1:0]              out_valid,
  input  logic                              out_ready,
  output logic [NUM_PORTS*XLEN-1:0]         out_src1_val,
  output logic [NUM_PORTS*XLEN-1:0]         out_src2_val,
  output logic [NUM_PORTS*PAYLOAD_W-1:0]    out_payload
`ifdef RR_BYPASS_STATS_EN
  ,
  output logic [31:0]                       stat_bypass_hits,
  output logic [31:0]                       stat_rf_reads
`endif
);

  localparam int unsigned NumSlots = 2 * NUM_PORTS;

  logic [XLEN-1:0] slot_val [NumSlots];
  bypass_sel_e     slot_sel [NumSlots];

  logic [NUM_PORTS-1:0]           valid_q;
  logic [NUM_PORTS*XLEN-1:0]      src1_q, src2_q, src1_d, src2_d;
  logic [NUM_PORTS*PAYLOAD_W-1:0] payload_q;
  logic                           capture;

  // Slot 2p carries src1 of lane p, slot 2p+1 carries src2.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    assign rf_rd_idx[(2*p)*PREG_IDX_W +: PREG_IDX_W]   = in_src1_idx[p*PREG_IDX_W +: PREG_IDX_W];
    assign rf_rd_idx[(2*p+1)*PREG_IDX_W +: PREG_IDX_W] = in_src2_idx[p*PREG_IDX_W +: PREG_IDX_W];

    operand_bypass_sel #(
      .NUM_BYPASS (NUM_BYPASS),
      .PREG_IDX_W (PREG_IDX_W),
      .XLEN       (XLEN)
    ) u_sel_src1 (
      .idx       (in_src1_idx[p*PREG_IDX_W +: PREG_IDX_W]),
      .byp_valid (byp_valid),
      .byp_dst   (byp_dst),
      .byp_value (byp_value),
      .rf_data   (rf_rd_data[(2*p)*XLEN +: XLEN]),
      .value     (slot_val[2*p]),
      .sel       (slot_sel[2*p])
    );

    operand_bypass_sel #(
      .NUM_BYPASS (NUM_BYPASS),
      .PREG_IDX_W (PREG_IDX_W),
      .XLEN       (XLEN)
    ) u_sel_src2 (
      .idx       (in_src2_idx[p*PREG_IDX_W +: PREG_IDX_W]),
      .byp_valid (byp_valid),
      .byp_dst   (byp_dst),
      .byp_value (byp_value),
      .rf_data   (rf_rd_data[(2*p+1)*XLEN +: XLEN]),
      .value     (slot_val[2*p+1]),
      .sel       (slot_sel[2*p+1])
    );

    assign src1_d[p*XLEN +: XLEN] = slot_val[2*p];
    assign src2_d[p*XLEN +: XLEN] = slot_val[2*p+1];
  end

  assign in_ready = !(|valid_q) || out_ready;
  assign capture  = (|in_valid) && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      payload_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (capture) begin
        src1_q    <= src1_d;
        src2_q    <= src2_d;
        payload_q <= in_payload;
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_src1_val = src1_q;
  assign out_src2_val = src2_q;
  assign out_payload  = payload_q;

`ifdef RR_BYPASS_STATS_EN
  logic [31:0] hit_cnt, rf_cnt, hits_q, rf_reads_q;

  always_comb begin
    hit_cnt = '0;
    rf_cnt  = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (in_valid[s/2]) begin
        if (slot_sel[s] == BYPASS) hit_cnt = hit_cnt + 32'd1;
        if (slot_sel[s] == REG_FILE) rf_cnt = rf_cnt + 32'd1;
      end
    end
  end

  // A flushed group is dropped, so it is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q     <= '0;
      rf_reads_q <= '0;
    end else if (capture && !flush) begin
      hits_q     <= sat_add32(hits_q, hit_cnt);
      rf_reads_q <= sat_add32(rf_reads_q, rf_cnt);
    end
  end

  assign stat_bypass_hits = hits_q;
  assign stat_rf_reads    = rf_reads_q;
`else
  logic unused_sel;
  always_comb begin
    unused_sel = 1'b0;
    for (int s = 0; s < NumSlots; s++) unused_sel = unused_sel ^ (^slot_sel[s]);
  end
`endif

endmodule

// File: tb/tb_reg_read_bypass_stage.sv
// Bench for reg_read_bypass_stage: directed vector table, corner sequences, random vs model.
module tb_reg_read_bypass_stage;

  localparam int NP = 2;
  localparam int NB = 4;
  localparam int IW = 6;
  localparam int XL = 32;
  localparam int PW = 64;

  logic                 clk = 1'b0;
  logic                 rst, flush, in_ready, out_ready;
  logic [NP-1:0]        in_valid, out_valid;
  logic [NP*IW-1:0]     in_src1_idx, in_src2_idx;
  logic [NP*PW-1:0]     in_payload, out_payload;
  logic [2*NP*IW-1:0]   rf_rd_idx;
  logic [2*NP*XL-1:0]   rf_rd_data;
  logic [NB-1:0]        byp_valid;
  logic [NB*IW-1:0]     byp_dst;
  logic [NB*XL-1:0]     byp_value;
  logic [NP*XL-1:0]     out_src1_val, out_src2_val;
`ifdef RR_BYPASS_STATS_EN
  logic [31:0]          stat_bypass_hits, stat_rf_reads;
`endif

  reg_read_bypass_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_src1_idx  (in_src1_idx),
    .in_src2_idx  (in_src2_idx),
    .in_payload   (in_payload),
    .rf_rd_idx    (rf_rd_idx),
    .rf_rd_data   (rf_rd_data),
    .byp_valid    (byp_valid),
    .byp_dst      (byp_dst),
    .byp_value    (byp_value),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_src1_val (out_src1_val),
    .out_src2_val (out_src2_val),
    .out_payload  (out_payload)
`ifdef RR_BYPASS_STATS_EN
    ,
    .stat_bypass_hits (stat_bypass_hits),
    .stat_rf_reads    (stat_rf_reads)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: what execute should see after the next edge.
  logic [NP-1:0] m_valid = '0;
  logic [XL-1:0] m_v1 [NP];
  logic [XL-1:0] m_v2 [NP];
  logic [PW-1:0] m_pay [NP];
  logic [31:0]   m_hits = '0;
  logic [31:0]   m_rfr  = '0;

  typedef struct {
    logic [IW-1:0]    s1, s2;
    logic [XL-1:0]    rf1, rf2;
    logic [NB-1:0]    bv;
    logic [NB*IW-1:0] bd;
    logic [NB*XL-1:0] bx;
    logic [XL-1:0]    e1, e2;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int lane, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lane=%0d got=%h want=%h t=%0t", name, lane, act, exp, $time);
    end
  endtask

  // Priority rule straight from the operand rules: x0, then first matching bypass, then regfile.
  function automatic logic [XL-1:0] resolve(input logic [IW-1:0] idx, input int slot,
                                            output bit from_byp);
    from_byp = 1'b0;
    if (idx == 0) return '0;
    for (int b = 0; b < NB; b++) begin
      if (byp_valid[b] && byp_dst[b*IW +: IW] == idx) begin
        from_byp = 1'b1;
        return byp_value[b*XL +: XL];
      end
    end
    return rf_rd_data[slot*XL +: XL];
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] a, input int n);
    longint s;
    s = longint'(a) + n;
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic tick();
    logic          exp_ready;
    logic [2*NP*IW-1:0] exp_idx;
    bit            fb;
    int            nh, nr;
    logic [IW-1:0] ix;
    #1;
    exp_ready = (m_valid == '0) || out_ready;
    for (int p = 0; p < NP; p++) begin
      exp_idx[(2*p)*IW +: IW]   = in_src1_idx[p*IW +: IW];
      exp_idx[(2*p+1)*IW +: IW] = in_src2_idx[p*IW +: IW];
    end
    chk("in_ready", -1, 64'(in_ready), 64'(exp_ready));
    chk("rf_rd_idx", -1, 64'(rf_rd_idx), 64'(exp_idx));
    if (rst) begin
      m_valid = '0;
      for (int p = 0; p < NP; p++) begin m_v1[p] = '0; m_v2[p] = '0; m_pay[p] = '0; end
      m_hits = '0;
      m_rfr  = '0;
    end else begin
      if (!flush && exp_ready && (in_valid != '0)) begin
        nh = 0;
        nr = 0;
        for (int p = 0; p < NP; p++) begin
          ix = in_src1_idx[p*IW +: IW];
          m_v1[p] = resolve(ix, 2*p, fb);
          if (in_valid[p] && ix != 0) begin if (fb) nh++; else nr++; end
          ix = in_src2_idx[p*IW +: IW];
          m_v2[p] = resolve(ix, 2*p+1, fb);
          if (in_valid[p] && ix != 0) begin if (fb) nh++; else nr++; end
          m_pay[p] = in_payload[p*PW +: PW];
        end
        m_hits = sat(m_hits, nh);
        m_rfr  = sat(m_rfr, nr);
      end
      if (flush) m_valid = '0;
      else if (exp_ready) m_valid = in_valid;
    end
    @(posedge clk);
    #1;
    chk("out_valid", -1, 64'(out_valid), 64'(m_valid));
    for (int p = 0; p < NP; p++) begin
      chk("out_src1_val", p, 64'(out_src1_val[p*XL +: XL]), 64'(m_v1[p]));
      chk("out_src2_val", p, 64'(out_src2_val[p*XL +: XL]), 64'(m_v2[p]));
      chk("out_payload", p, out_payload[p*PW +: PW], m_pay[p]);
    end
`ifdef RR_BYPASS_STATS_EN
    chk("stat_bypass_hits", -1, 64'(stat_bypass_hits), 64'(m_hits));
    chk("stat_rf_reads", -1, 64'(stat_rf_reads), 64'(m_rfr));
`endif
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = '0; in_src1_idx = '0; in_src2_idx = '0; in_payload = '0;
    rf_rd_data = '0; byp_valid = '0; byp_dst = '0; byp_value = '0;
  endtask

  task automatic set_lane(input int p, input logic [IW-1:0] s1, input logic [IW-1:0] s2,
                          input logic [XL-1:0] r1, input logic [XL-1:0] r2,
                          input logic [PW-1:0] pay);
    in_src1_idx[p*IW +: IW]     = s1;
    in_src2_idx[p*IW +: IW]     = s2;
    rf_rd_data[(2*p)*XL +: XL]   = r1;
    rf_rd_data[(2*p+1)*XL +: XL] = r2;
    in_payload[p*PW +: PW]       = pay;
  endtask

  initial begin
    vecs[0] = '{s1: 6'd5, s2: 6'd7, rf1: 32'h11, rf2: 32'h22, bv: 4'b0000, bd: '0, bx: '0,
                e1: 32'h11, e2: 32'h22};
    vecs[1] = '{s1: 6'd9, s2: 6'd4, rf1: 32'h1, rf2: 32'h2, bv: 4'b1010,
                bd: {6'd9, 6'd0, 6'd9, 6'd0}, bx: {32'hBB, 32'h0, 32'hAA, 32'h0},
                e1: 32'hAA, e2: 32'h2};
    vecs[2] = '{s1: 6'd9, s2: 6'd4, rf1: 32'h1, rf2: 32'h2, bv: 4'b1000,
                bd: {6'd9, 6'd0, 6'd9, 6'd0}, bx: {32'hBB, 32'h0, 32'hAA, 32'h0},
                e1: 32'hBB, e2: 32'h2};
    vecs[3] = '{s1: 6'd0, s2: 6'd0, rf1: 32'hDEAD, rf2: 32'hBEEF, bv: 4'b0001, bd: '0,
                bx: {32'h0, 32'h0, 32'h0, 32'h77}, e1: 32'h0, e2: 32'h0};
    vecs[4] = '{s1: 6'd3, s2: 6'd3, rf1: 32'h5, rf2: 32'h6, bv: 4'b0110,
                bd: {6'd0, 6'd3, 6'd3, 6'd0}, bx: {32'h0, 32'hCC, 32'hDD, 32'h0},
                e1: 32'hDD, e2: 32'hDD};
    vecs[5] = '{s1: 6'd12, s2: 6'd13, rf1: 32'h5, rf2: 32'h6, bv: 4'b1111,
                bd: {6'd13, 6'd13, 6'd12, 6'd1}, bx: {32'h4, 32'h3, 32'h2, 32'h1},
                e1: 32'h2, e2: 32'h3};

    clear_inputs();
    out_ready = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;

    // Directed vector table on lane 0.
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      in_valid = 2'b01;
      set_lane(0, vecs[i].s1, vecs[i].s2, vecs[i].rf1, vecs[i].rf2, 64'(i + 100));
      byp_valid = vecs[i].bv;
      byp_dst   = vecs[i].bd;
      byp_value = vecs[i].bx;
      tick();
      chk("vec_valid", i, 64'(out_valid), 64'h1);
      chk("vec_src1", i, 64'(out_src1_val[XL-1:0]), 64'(vecs[i].e1));
      chk("vec_src2", i, 64'(out_src2_val[XL-1:0]), 64'(vecs[i].e2));
    end

    // Stall: group held bit-exact while bypass shows a newer value for the same register.
    clear_inputs();
    in_valid = 2'b01;
    set_lane(0, 6'd3, 6'd0, 32'h55, 32'h0, 64'hABCD);
    tick();
    out_ready = 0;
    in_valid = 2'b11;
    set_lane(1, 6'd4, 6'd5, 32'h66, 32'h77, 64'h1234);
    byp_valid = 4'b0001;
    byp_dst   = {6'd0, 6'd0, 6'd0, 6'd3};
    byp_value = {32'h0, 32'h0, 32'h0, 32'h99};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready", i, 64'(in_ready), 64'h0);
      chk("stall_src1", i, 64'(out_src1_val[XL-1:0]), 64'h55);
      chk("stall_payload", i, out_payload[PW-1:0], 64'hABCD);
    end
    out_ready = 1;
    tick();
    chk("unstall_valid", -1, 64'(out_valid), 64'h3);
    chk("unstall_src1", -1, 64'(out_src1_val[XL-1:0]), 64'h99);

    // Flush drops an incoming group, and clears a held one.
    flush = 1;
    tick();
    chk("flush_in", -1, 64'(out_valid), 64'h0);
    flush = 0;
    tick();
    out_ready = 0;
    tick();
    flush = 1;
    tick();
    chk("flush_stall", -1, 64'(out_valid), 64'h0);
    flush = 0;

    // Reset mid-stall.
    out_ready = 1;
    in_valid = 2'b11;
    tick();
    out_ready = 0;
    tick();
    rst = 1;
    tick();
    chk("rst_valid", -1, 64'(out_valid), 64'h0);
    chk("rst_src1", -1, 64'(out_src1_val), 64'h0);
    rst = 0;
    out_ready = 1;

    // Random traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      in_valid = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        set_lane(p, IW'($urandom_range(0, 7)), IW'($urandom_range(0, 7)), $urandom, $urandom,
                 {$urandom, $urandom});
      end
      byp_valid = NB'($urandom);
      for (int b = 0; b < NB; b++) begin
        byp_dst[b*IW +: IW]   = IW'($urandom_range(0, 7));
        byp_value[b*XL +: XL] = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
